mux4_scan_sequencer: RTL and testbench

MUX4_SCAN_SEQUENCER -- requirements
Module: mux4_scan_sequencer

---
 rtl/mux4_scan_pkg.sv | 21 ++
 rtl/mux4_scan_dwell_cnt.sv | 38 +++
 rtl/mux4_scan_sequencer.sv | 133 +++++++++++++
 tb/tb_mux4_scan_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mux4_scan_pkg.sv
// Shared types and channel constants for the 4-channel mux scan sequencer.
package mux4_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Channel index; S0 is the upper bit, S1 the lower bit.
  typedef logic [1:0] ch_t;

  localparam ch_t CH_A = 2'd0;
  localparam ch_t CH_B = 2'd1;
  localparam ch_t CH_C = 2'd2;
  localparam ch_t CH_D = 2'd3;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CNT_W   = 8;

endpackage

// File: rtl/mux4_scan_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps on terminal count.
module mux4_scan_dwell_cnt #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_c_o = (cnt_q == CW'(DWELL - 1));

  // Next count: clear dominates, otherwise advance and wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_c_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux4_scan_sequencer.sv
// Steps a 4:1 mux through channels A..D, samples Z at the end of each dwell
// window, and hands the 4-bit snapshot to a consumer over valid/ready.
module mux4_scan_sequencer
  import mux4_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     Z,
  output logic                     S0,
  output logic                     S1,
  output logic                     busy,
  output logic [NUM_CH-1:0]        snap,
  output logic                     valid,
  input  logic                     ready,
  output logic [CNT_W-1:0]         scan_cnt
);

  state_e              state_q, state_d;
  ch_t                 ch_q, ch_d;
  logic [NUM_CH-1:0]   shadow_q, shadow_d;
  logic [NUM_CH-1:0]   snap_q, snap_d;
  logic                valid_q, valid_d;
  logic                busy_q;
  logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic                cnt_clr;
  logic                cnt_en;
  logic                dwell_tc;

  mux4_scan_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_c_o (dwell_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: if (dwell_tc && (ch_q == CH_D)) state_d = ST_DONE;
      ST_DONE: if (valid_q && ready) state_d = cont ? ST_SCAN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: channel stepping, Z capture, hand-off bookkeeping.
  always_comb begin
    ch_d       = ch_q;
    shadow_d   = shadow_q;
    snap_d     = snap_q;
    valid_d    = valid_q;
    scan_cnt_d = scan_cnt_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ch_d    = CH_A;
        valid_d = 1'b0;
        cnt_clr = 1'b1;
      end
      ST_SCAN: begin
        cnt_en = 1'b1;
        if (dwell_tc) begin
          shadow_d[ch_q] = Z;
          if (ch_q == CH_D) begin
            snap_d  = shadow_d;
            valid_d = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            ch_d = ch_q + ch_t'(1);
          end
        end
      end
      ST_DONE: begin
        if (valid_q && ready) begin
          scan_cnt_d = scan_cnt_q + CNT_W'(1);
          valid_d    = 1'b0;
          ch_d       = CH_A;
          cnt_clr    = 1'b1;
        end
      end
      default: begin
        ch_d    = CH_A;
        valid_d = 1'b0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q       <= CH_A;
      shadow_q   <= '0;
      snap_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      scan_cnt_q <= '0;
    end else begin
      ch_q       <= ch_d;
      shadow_q   <= shadow_d;
      snap_q     <= snap_d;
      valid_q    <= valid_d;
      busy_q     <= (state_d == ST_SCAN);
      scan_cnt_q <= scan_cnt_d;
    end
  end

  assign S0       = ch_q[1];
  assign S1       = ch_q[0];
  assign busy     = busy_q;
  assign snap     = snap_q;
  assign valid    = valid_q;
  assign scan_cnt = scan_cnt_q;

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Randomized directed bench for mux4_scan_sequencer with DWELL=4 and DWELL=1.
module tb_mux4_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, cont, Z, ready;

  logic       s0_4, s1_4, busy_4, valid_4;
  logic [3:0] snap_4;
  logic [7:0] cnt_4;
  logic       s0_1, s1_1, busy_1, valid_1;
  logic [3:0] snap_1;
  logic [7:0] cnt_1;

  mux4_scan_sequencer #(.DWELL(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .Z(Z),
    .S0(s0_4), .S1(s1_4), .busy(busy_4), .snap(snap_4),
    .valid(valid_4), .ready(ready), .scan_cnt(cnt_4)
  );

  mux4_scan_sequencer #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .Z(Z),
    .S0(s0_1), .S1(s1_1), .busy(busy_1), .snap(snap_1),
    .valid(valid_1), .ready(ready), .scan_cnt(cnt_1)
  );

  // Observed outputs of whichever instance is under test.
  bit          sel1;
  int          dw;
  logic        o_s0, o_s1, o_busy, o_valid;
  logic [3:0]  o_snap;
  logic [7:0]  o_cnt;
  assign o_s0    = sel1 ? s0_1    : s0_4;
  assign o_s1    = sel1 ? s1_1    : s1_4;
  assign o_busy  = sel1 ? busy_1  : busy_4;
  assign o_valid = sel1 ? valid_1 : valid_4;
  assign o_snap  = sel1 ? snap_1  : snap_4;
  assign o_cnt   = sel1 ? cnt_1   : cnt_4;

  int         tests;
  int         failed;
  logic [7:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scan from the model's point of view: channel c is selected during
  // scan cycles c*dw+1 .. (c+1)*dw, and snap bit c is Z on the last of them.
  // smode: 0 = Z stable, 1 = random settling, 2 = toggling settling.
  task automatic do_scan(input logic [3:0] zbits, input int smode, input bit already,
                         input int hold, input bit contm);
    int n;
    n = 4 * dw;
    if (!already) begin
      start = 1'b1;
      ready = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
    end
    for (int k = 1; k <= n; k++) begin
      automatic int ch = (k - 1) / dw;
      chk("scan_sel", 32'({o_s0, o_s1}), 32'(ch));
      chk("scan_busy_valid", 32'({o_busy, o_valid}), 32'b10);
      if ((k % dw) == 0)  Z = zbits[ch];
      else if (smode == 0) Z = zbits[ch];
      else if (smode == 1) Z = 1'($urandom);
      else                 Z = 1'(k);
      start = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      cont  = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    chk("done_flags", 32'({o_valid, o_busy, o_s0, o_s1}), 32'b1011);
    chk("done_snap", 32'(o_snap), 32'(zbits));
    chk("done_cnt", 32'(o_cnt), 32'(exp_cnt));
    for (int i = 0; i < hold; i++) begin
      ready = 1'b0;
      start = 1'($urandom_range(0, 1));
      cont  = 1'($urandom_range(0, 1));
      Z     = 1'($urandom);
      tick();
      chk("hold_flags", 32'({o_valid, o_busy, o_s0, o_s1}), 32'b1011);
      chk("hold_snap", 32'(o_snap), 32'(zbits));
    end
    ready = 1'b1;
    cont  = contm;
    start = 1'($urandom_range(0, 1));
    tick();
    ready = 1'b0;
    start = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("hs_flags", 32'({o_valid, o_busy, o_s0, o_s1}), 32'({1'b0, contm, 2'b00}));
    chk("hs_cnt", 32'(o_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; failed = 0; exp_cnt = 8'd0;
    sel1 = 1'b0; dw = 4;
    rst = 1'b1; start = 1'b0; cont = 1'b0; Z = 1'b0; ready = 1'b0;
    tick();
    tick();

    // Reset values on both instances.
    chk("reset_dut4", 32'({s0_4, s1_4, busy_4, valid_4, snap_4, cnt_4}), 32'd0);
    chk("reset_dut1", 32'({s0_1, s1_1, busy_1, valid_1, snap_1, cnt_1}), 32'd0);

    // Reset beats start.
    start = 1'b1;
    tick();
    chk("rst_over_start", 32'({o_busy, o_valid, o_s0, o_s1}), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("idle_after_rst", 32'({o_busy, o_valid}), 32'd0);

    // Ready in IDLE is ignored.
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("idle_ready", 32'({o_busy, o_valid, o_cnt}), 32'd0);

    // A..D = 1,0,1,1 -> snap 1101.
    do_scan(4'b1101, 0, 1'b0, 0, 1'b0);
    // Toggling Z while settling, stable on the sample cycle.
    do_scan(4'b0010, 2, 1'b0, 0, 1'b0);
    // Random snapshots with random settling and random consumer delay.
    repeat (4) do_scan(4'($urandom), 1, 1'b0, $urandom_range(0, 3), 1'b0);
    // Consumer stalls 10 cycles with start pulses in DONE.
    do_scan(4'($urandom), 1, 1'b0, 10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
      chk("idle_after_stall", 32'({o_busy, o_valid, o_s0, o_s1}), 32'd0);
    end
    ready = 1'b0;

    // Continuous mode: 256 back-to-back scans wrap scan_cnt back to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 8'd0;
    do_scan(4'b1010, 0, 1'b0, 0, 1'b1);
    for (int s = 0; s < 254; s++) do_scan(4'b1010, 0, 1'b1, 0, 1'b1);
    do_scan(4'b1010, 0, 1'b1, 0, 1'b0);
    chk("cnt_wrapped", 32'(o_cnt), 32'd0);

    // Reset in the middle of channel C's dwell.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 2 * dw + 2; k++) begin
      Z = 1'($urandom);
      tick();
    end
    chk("mid_ch2_sel", 32'({o_s0, o_s1, o_busy}), 32'b101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 8'd0;
    chk("mid_rst_zero", 32'({o_s0, o_s1, o_busy, o_valid, o_snap, o_cnt}), 32'd0);
    for (int i = 0; i < 40; i++) begin
      ready = 1'($urandom_range(0, 1));
      Z     = 1'($urandom);
      tick();
      chk("no_valid_after_rst", 32'({o_busy, o_valid, o_snap}), 32'd0);
    end
    ready = 1'b0;
    do_scan(4'($urandom), 1, 1'b0, 1, 1'b0);

    // DWELL=1 instance: one cycle per channel, valid 5 cycles after start.
    sel1 = 1'b1; dw = 1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 8'd0;
    chk("d1_reset", 32'({o_s0, o_s1, o_busy, o_valid, o_snap, o_cnt}), 32'd0);
    do_scan(4'($urandom), 1, 1'b0, 0, 1'b0);
    do_scan(4'($urandom), 1, 1'b0, 2, 1'b1);
    do_scan(4'($urandom), 1, 1'b1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
